// File: rtl/gi_mixcol.sv
// AES MixColumns engine: forward / inverse / bypass over NCOL columns, PIPE-deep valid/ready pipeline.
// Define GI_MIXCOL_INV_EN to build the inverse datapath; otherwise mode 01 is handled as forward.
module gi_mixcol #(
    parameter int NCOL = 4,
    parameter int PIPE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    input  logic [32*NCOL-1:0]   in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_last,
    output logic [32*NCOL-1:0]   out_data,
    output logic                 busy
);

    localparam int DW = 32 * NCOL;
`ifdef GI_MIXCOL_INV_EN
    localparam int PPW = 4 * 32;
`else
    localparam int PPW = 2 * 32;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] xtime_col(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = xtime(c[8*i +: 8]);
        return r;
    endfunction

    // Partial products per column, packed as {x8, x4, x2, a} (x8/x4 only with the inverse path).
    function automatic logic [PPW-1:0] pp_col(input logic [31:0] a);
        logic [31:0] x2;
`ifdef GI_MIXCOL_INV_EN
        logic [31:0] x4;
        logic [31:0] x8;
`endif
        x2 = xtime_col(a);
`ifdef GI_MIXCOL_INV_EN
        x4 = xtime_col(x2);
        x8 = xtime_col(x4);
        return {x8, x4, x2, a};
`else
        return {x2, a};
`endif
    endfunction

    function automatic logic [31:0] mix_col(input logic [PPW-1:0] pp, input logic [1:0] mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [31:0] fwd;
`ifdef GI_MIXCOL_INV_EN
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] inv;
`endif
        for (int r = 0; r < 4; r++) begin
            a[r]  = pp[31-8*r -: 8];
            x2[r] = pp[63-8*r -: 8];
`ifdef GI_MIXCOL_INV_EN
            x4[r] = pp[95-8*r -: 8];
            x8[r] = pp[127-8*r -: 8];
`endif
        end
        for (int r = 0; r < 4; r++) begin
            fwd[31-8*r -: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`ifdef GI_MIXCOL_INV_EN
            // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
            inv[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
`endif
        end
        if (mode inside {2'b10, 2'b11}) return pp[31:0];
`ifdef GI_MIXCOL_INV_EN
        if (mode == 2'b01) return inv;
`endif
        return fwd;
    endfunction

    function automatic logic [NCOL*PPW-1:0] pp_beat(input logic [DW-1:0] d);
        logic [NCOL*PPW-1:0] r;
        for (int k = 0; k < NCOL; k++) r[PPW*k +: PPW] = pp_col(d[32*k +: 32]);
        return r;
    endfunction

    function automatic logic [DW-1:0] mix_beat(input logic [NCOL*PPW-1:0] pp, input logic [1:0] mode);
        logic [DW-1:0] r;
        for (int k = 0; k < NCOL; k++) r[32*k +: 32] = mix_col(pp[PPW*k +: PPW], mode);
        return r;
    endfunction

    if (PIPE == 1) begin : g_pipe1
        logic          vld_p0;
        logic          last_p0;
        logic [DW-1:0] res_p0;
        logic          acc;

        assign in_rdy = (~vld_p0 | out_rdy) & ~flush;
        assign acc    = in_vld & in_rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 vld_p0 <= 1'b0;
            else if (flush)             vld_p0 <= 1'b0;
            else if (~vld_p0 | out_rdy) vld_p0 <= in_vld;
        end

        // single stage: full mix registered at the output
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_p0  <= '0;
                last_p0 <= 1'b0;
            end else if (acc) begin
                res_p0  <= mix_beat(pp_beat(in_data), in_mode);
                last_p0 <= in_last;
            end
        end

        assign out_vld  = vld_p0;
        assign out_data = res_p0;
        assign out_last = last_p0;
        assign busy     = vld_p0;
    end else begin : g_pipe2
        logic                vld_p0;
        logic                vld_p1;
        logic                adv_p0;
        logic                acc;
        logic [NCOL*PPW-1:0] pp_p0;
        logic [1:0]          mode_p0;
        logic                last_p0;
        logic [DW-1:0]       res_p1;
        logic                last_p1;

        assign adv_p0 = ~vld_p1 | out_rdy;
        assign in_rdy = (~vld_p0 | adv_p0) & ~flush;
        assign acc    = in_vld & in_rdy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else if (flush) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else begin
                if (~vld_p0 | adv_p0) vld_p0 <= in_vld;
                if (adv_p0)           vld_p1 <= vld_p0;
            end
        end

        // stage 1: input column, tags and xtime partial products
        always_ff @(posedge clk) begin
            if (acc) begin
                pp_p0   <= pp_beat(in_data);
                mode_p0 <= in_mode;
                last_p0 <= in_last;
            end
        end

        // stage 2: XOR-reduced result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_p1  <= '0;
                last_p1 <= 1'b0;
            end else if (vld_p0 & adv_p0 & ~flush) begin
                res_p1  <= mix_beat(pp_p0, mode_p0);
                last_p1 <= last_p0;
            end
        end

        assign out_vld  = vld_p1;
        assign out_data = res_p1;
        assign out_last = last_p1;
        assign busy     = vld_p0 | vld_p1;
    end

endmodule
